// File: rtl/clk_div_1x4.sv
// Four-channel programmable clock divider fed from one source clock.
// Divisor changes take effect only at each channel's period boundary, so no runt pulses are produced.
module clk_div_1x4 #(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [4*DIV_W-1:0] div_i,
    input  logic               div_valid_i,
    output logic               div_ready_o,
    input  logic [3:0]         clk_en_i,
    output logic [3:0]         clk_out,
    output logic [3:0]         tick_o
);

    typedef enum logic [1:0] {CH_STOP, CH_RUN, CH_DRAIN} ch_state_e;
    typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_e;

    localparam logic [DIV_W-1:0] RST_N = DIV_W'(RST_DIV);

    ch_state_e        ch_q[4], ch_d[4];
    logic [DIV_W-1:0] cnt_q[4], cnt_d[4];
    logic [DIV_W-1:0] div_q[4], div_d[4];
    logic [DIV_W-1:0] pend_q[4], pend_d[4];
    logic [3:0]       applied_q, applied_d;
    logic [3:0]       clk_d, tick_d, wrap_c;
    upd_state_e       upd_q, upd_d;
    logic             accept_c;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
        return (n < DIV_W'(2)) ? DIV_W'(2) : n;
    endfunction

    assign div_ready_o = (upd_q == UPD_IDLE);

    always_comb begin
        upd_d     = upd_q;
        applied_d = applied_q;
        clk_d     = '0;
        tick_d    = '0;
        wrap_c    = '0;
        accept_c  = (upd_q == UPD_IDLE) && div_valid_i;
        for (int k = 0; k < 4; k++) begin
            ch_d[k]   = ch_q[k];
            cnt_d[k]  = cnt_q[k];
            div_d[k]  = div_q[k];
            pend_d[k] = pend_q[k];
        end

        for (int k = 0; k < 4; k++) begin
            wrap_c[k] = (ch_q[k] != CH_STOP) && (cnt_q[k] == div_q[k] - DIV_W'(1));

            // Stopped channels adopt immediately; running ones only at the wrap edge.
            if (upd_q == UPD_PEND && !applied_q[k] && (ch_q[k] == CH_STOP || wrap_c[k])) begin
                div_d[k]     = pend_q[k];
                applied_d[k] = 1'b1;
            end

            case (ch_q[k])
                CH_STOP: begin
                    cnt_d[k] = '0;
                    if (clk_en_i[k])
                        ch_d[k] = CH_RUN;
                end
                default: begin
                    if (wrap_c[k]) begin
                        cnt_d[k] = '0;
                        ch_d[k]  = clk_en_i[k] ? CH_RUN : CH_STOP;
                    end else begin
                        cnt_d[k] = cnt_q[k] + DIV_W'(1);
                        ch_d[k]  = clk_en_i[k] ? CH_RUN : CH_DRAIN;
                    end
                end
            endcase

            clk_d[k]  = (ch_d[k] != CH_STOP) && (cnt_d[k] < (div_d[k] - (div_d[k] >> 1)));
            tick_d[k] = (ch_d[k] != CH_STOP) && (cnt_d[k] == div_d[k] - DIV_W'(1));
        end

        if (upd_q == UPD_PEND && (&applied_d))
            upd_d = UPD_IDLE;

        if (accept_c) begin
            upd_d     = UPD_PEND;
            applied_d = '0;
            for (int k = 0; k < 4; k++)
                pend_d[k] = clamp_div(div_i[k*DIV_W +: DIV_W]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            upd_q     <= UPD_IDLE;
            applied_q <= '1;
            clk_out   <= '0;
            tick_o    <= '0;
            for (int k = 0; k < 4; k++) begin
                ch_q[k]   <= CH_STOP;
                cnt_q[k]  <= '0;
                div_q[k]  <= RST_N;
                pend_q[k] <= '0;
            end
        end else begin
            upd_q     <= upd_d;
            applied_q <= applied_d;
            clk_out   <= clk_d;
            tick_o    <= tick_d;
            for (int k = 0; k < 4; k++) begin
                ch_q[k]   <= ch_d[k];
                cnt_q[k]  <= cnt_d[k];
                div_q[k]  <= div_d[k];
                pend_q[k] <= pend_d[k];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_1x4.sv
// Bench for clk_div_1x4: per-cycle comparison against a period-position model,
// plus directed literal waveform checks.
module tb_clk_div_1x4;

    localparam int DIV_W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  div = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic [3:0]   en = '0;
    logic [3:0]   clk_out;
    logic [3:0]   tick;

    int checks = 0;
    int errors = 0;

    clk_div_1x4 #(.DIV_W(DIV_W), .RST_DIV(2)) dut (
        .clk_in(clk), .rst(rst), .div_i(div), .div_valid_i(valid),
        .div_ready_o(ready), .clk_en_i(en), .clk_out(clk_out), .tick_o(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is either off or at position pos within a period of n cycles.
    bit m_on[4];
    int m_pos[4], m_n[4], m_pn[4];
    bit m_app[4];
    bit m_pend = 0;
    bit m_live = 0;

    function automatic int clampn(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge clk) begin
        bit pend_now, all_app, boundary;
        logic [8:0] exp_v;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_on[k] = 0; m_pos[k] = 0; m_n[k] = 2; m_app[k] = 1;
            end
            m_pend = 0;
            m_live = 1;
        end else begin
            pend_now = m_pend;
            for (int k = 0; k < 4; k++) begin
                boundary = m_on[k] && (m_pos[k] == m_n[k] - 1);
                if (pend_now && !m_app[k] && (!m_on[k] || boundary)) begin
                    m_n[k] = m_pn[k];
                    m_app[k] = 1;
                end
                if (!m_on[k]) begin
                    if (en[k]) begin m_on[k] = 1; m_pos[k] = 0; end
                end else if (boundary) begin
                    m_pos[k] = 0;
                    m_on[k] = en[k];
                end else begin
                    m_pos[k]++;
                end
            end
            all_app = 1;
            for (int k = 0; k < 4; k++) if (!m_app[k]) all_app = 0;
            if (pend_now && all_app) m_pend = 0;
            if (!pend_now && valid) begin
                m_pend = 1;
                for (int k = 0; k < 4; k++) begin
                    m_app[k] = 0;
                    m_pn[k] = clampn(int'(div[k*DIV_W +: DIV_W]));
                end
            end
        end
        #1;
        if (m_live) begin
            exp_v = '0;
            exp_v[8] = !m_pend;
            for (int k = 0; k < 4; k++) begin
                exp_v[k]     = m_on[k] && (m_pos[k] < m_n[k] - m_n[k] / 2);
                exp_v[4 + k] = m_on[k] && (m_pos[k] == m_n[k] - 1);
            end
            chk("cycle_model", {23'd0, ready, tick, clk_out}, {23'd0, exp_v});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(input int k, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (tick[k] !== 1'b1 && c < 200);
        if (tick[k] !== 1'b1) chk("wait_tick_timeout", 32'(tick[k]), 1);
    endtask

    task automatic wait_ready();
        int c = 0;
        while (ready !== 1'b1 && c < 200) begin
            step();
            c++;
        end
        if (ready !== 1'b1) chk("wait_ready_timeout", 32'(ready), 1);
    endtask

    task automatic check_pat(input int k, input int n, input logic [15:0] pat, input string name);
        int c;
        wait_tick(k, c);
        for (int i = 0; i < n; i++) begin
            step();
            chk(name, 32'(clk_out[k]), 32'(pat[i]));
        end
        chk({name, "_tick"}, 32'(tick[k]), 1);
    endtask

    initial begin
        int c, v;
        // Reset state
        step(); step();
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ready", 32'(ready), 1);

        // Channel 0 alone at the reset divisor
        rst = 1'b0; en = 4'b0001;
        step(); chk("t1_c0", 32'(clk_out[0]), 1); chk("t1_k0", 32'(tick[0]), 0);
        step(); chk("t1_c1", 32'(clk_out[0]), 0); chk("t1_k1", 32'(tick[0]), 1);
        step(); chk("t1_c2", 32'(clk_out[0]), 1);
        step(); chk("t1_c3", 32'(clk_out[0]), 0); chk("t1_others", 32'(clk_out[3:1]), 0);

        // Program {1,3,4,7} and run all channels
        div = {8'd1, 8'd3, 8'd4, 8'd7}; valid = 1'b1; en = 4'hf;
        step(); valid = 1'b0;
        chk("t2_ready_low", 32'(ready), 0);
        wait_ready();
        check_pat(1, 4, 16'b0011, "t2_ch1");
        check_pat(2, 3, 16'b011, "t2_ch2");
        check_pat(3, 2, 16'b01, "t2_ch3");
        check_pat(0, 7, 16'b0001111, "t2_ch0");

        // Mid-period update of channel 0 from 8 to 3
        div = {8'd1, 8'd3, 8'd4, 8'd8}; valid = 1'b1;
        step(); valid = 1'b0;
        wait_ready();
        wait_tick(0, c);
        step(); step(); step();
        div = {8'd1, 8'd3, 8'd4, 8'd3}; valid = 1'b1;
        step(); valid = 1'b0;
        chk("t3_ready_low", 32'(ready), 0);
        wait_tick(0, c);
        chk("t3_old_tail", c, 4);
        chk("t3_ready_still_low", 32'(ready), 0);
        wait_tick(0, c);
        chk("t3_new_period", c, 3);
        wait_ready();

        // Drop enable on channel 1 mid-period, then restart
        wait_tick(1, c);
        step(); step();
        chk("t4_c1", 32'(clk_out[1]), 1);
        en[1] = 1'b0;
        step(); chk("t4_d0", 32'(clk_out[1]), 0); chk("t4_dk0", 32'(tick[1]), 0);
        step(); chk("t4_d1", 32'(clk_out[1]), 0); chk("t4_dk1", 32'(tick[1]), 1);
        step(); chk("t4_d2", 32'(clk_out[1]), 0); chk("t4_dk2", 32'(tick[1]), 0);
        step(); chk("t4_d3", 32'(clk_out[1]), 0);
        en[1] = 1'b1;
        step(); chk("t4_restart", 32'(clk_out[1]), 1);

        // valid held through PEND while div_i keeps changing
        div = {8'd2, 8'd2, 8'd2, 8'd5}; valid = 1'b1;
        step();
        chk("t5_ready_low", 32'(ready), 0);
        v = 0;
        for (int i = 0; i < 100; i++) begin
            v = 6 + (i % 4);
            div[7:0] = 8'(v);
            step();
            if (ready === 1'b1) break;
        end
        chk("t5_ready_back", 32'(ready), 1);
        step(); valid = 1'b0;
        chk("t5_second_accept", 32'(ready), 0);
        wait_ready();
        wait_tick(0, c);
        wait_tick(0, c);
        chk("t5_second_period", c, v);

        // Reset while an update is pending
        div = {8'd3, 8'd3, 8'd3, 8'd3}; valid = 1'b1;
        step(); valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t6_clk", 32'(clk_out), 0);
        chk("t6_tick", 32'(tick), 0);
        chk("t6_ready", 32'(ready), 1);
        rst = 1'b0; en = 4'b0001;
        step(); chk("t6_c0", 32'(clk_out[0]), 1);
        step(); chk("t6_c1", 32'(clk_out[0]), 0); chk("t6_k1", 32'(tick[0]), 1);
        step(); chk("t6_c2", 32'(clk_out[0]), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            valid = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++) div[k*8 +: 8] = 8'($urandom_range(0, 9));
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; valid = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
